fact_engine: RTL and testbench



---
 rtl/fact_pkg.sv | 7 +
 rtl/fact_dp.sv | 62 ++++++
 rtl/fact_engine.sv | 83 ++++++++
 tb/tb_fact_engine.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default sizes for the factorial engine.
package fact_pkg;
  typedef enum logic [1:0] {IDLE, INIT, LOOP, DONE} fact_state_t;

  localparam int XW_DEF = 8;
  localparam int W_DEF  = 8;
endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: operand/counter/accumulator registers, multiplier and overflow detect.
// Saturating result on overflow is enabled by defining FACT_OVF_SAT_EN.
module fact_dp
  import fact_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int W  = W_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ld_x,
  input  logic          ld_i,
  input  logic          ld_fi,
  input  logic          ld_o,
  input  logic          st,
  input  logic [XW-1:0] x,
  output logic          i_lt_x,
  output logic [W-1:0]  fi_out,
  output logic          ovf
);
  logic [XW-1:0]  x_r;
  logic [XW-1:0]  i;
  logic [W-1:0]   fi;
  logic           ovf_int;
  logic [XW:0]    i_inc;
  logic [W+XW:0]  prod;

  // i never exceeds x_r, so i+1 always fits in XW+1 bits.
  assign i_inc  = {1'b0, i} + (XW+1)'(1);
  assign prod   = (W+XW+1)'(fi) * (W+XW+1)'(i_inc);
  assign i_lt_x = (i < x_r);

  function automatic logic [W-1:0] result_sel(input logic [W-1:0] v, input logic o);
`ifdef FACT_OVF_SAT_EN
    return o ? {W{1'b1}} : v;
`else
    return o ? v : v;
`endif
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_r     <= '0;
      i       <= '0;
      fi      <= '0;
      ovf_int <= 1'b0;
      fi_out  <= '0;
      ovf     <= 1'b0;
    end else begin
      if (ld_x) x_r <= x;
      if (ld_i) i <= st ? XW'(1) : i_inc[XW-1:0];
      if (ld_fi) begin
        fi      <= st ? W'(1) : prod[W-1:0];
        ovf_int <= st ? 1'b0 : (ovf_int | (|prod[W+XW:W]));
      end
      if (ld_o) begin
        fi_out <= result_sel(fi, ovf_int);
        ovf    <= ovf_int;
      end
    end
  end
endmodule

// File: rtl/fact_engine.sv
// Iterative factorial unit: start/busy/done controller around fact_dp.
// Build with FACT_OVF_SAT_EN to saturate fi_out to all ones on overflow.
module fact_engine
  import fact_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int W  = W_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic [XW-1:0] X,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  fi_out,
  output logic          ovf
);
  fact_state_t state;
  logic        ld_x, ld_i, ld_fi, ld_o, st;
  logic        i_lt_x;

  always_comb begin
    ld_x  = 1'b0;
    ld_i  = 1'b0;
    ld_fi = 1'b0;
    ld_o  = 1'b0;
    st    = 1'b0;
    case (state)
      IDLE: ld_x = start;
      INIT: begin
        ld_i  = 1'b1;
        ld_fi = 1'b1;
        st    = 1'b1;
      end
      LOOP: begin
        ld_i  = i_lt_x;
        ld_fi = i_lt_x;
        ld_o  = !i_lt_x;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= INIT;
          busy  <= 1'b1;
        end
        INIT: state <= LOOP;
        LOOP: if (!i_lt_x) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fact_dp #(.XW(XW), .W(W)) u_dp (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ld_x   (ld_x),
    .ld_i   (ld_i),
    .ld_fi  (ld_fi),
    .ld_o   (ld_o),
    .st     (st),
    .x      (X),
    .i_lt_x (i_lt_x),
    .fi_out (fi_out),
    .ovf    (ovf)
  );
endmodule

// File: tb/tb_fact_engine.sv
// Randomized self-checking bench for fact_engine (W=8 and W=16 instances).
module tb_fact_engine;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, start16;
  logic [7:0]  X, X16;
  logic        busy, done, ovf;
  logic [7:0]  fi_out;
  logic        busy16, done16, ovf16;
  logic [15:0] fi16;

  int tests = 0;
  int fails = 0;
  longint unsigned prev_f = 0;

  always #5 CLK = ~CLK;

  fact_engine #(.XW(8), .W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .X(X),
    .busy(busy), .done(done), .fi_out(fi_out), .ovf(ovf)
  );

  fact_engine #(.XW(8), .W(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .start(start16), .X(X16),
    .busy(busy16), .done(done16), .fi_out(fi16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: X! reduced mod 2^w, overflow whenever the true value no longer fits.
  function automatic void model(input int x, input int w, output longint unsigned f, output bit o);
    longint unsigned lim = 64'd1 << w;
    f = 1;
    o = 0;
    for (int k = 2; k <= x; k++) begin
      f = f * k;
      if (f >= lim) begin
        o = 1;
        f = f % lim;
      end
    end
`ifdef FACT_OVF_SAT_EN
    if (o) f = lim - 1;
`endif
  endfunction

  // Entered and left at a negedge with the engine idle.
  task automatic run8(input int x, input bit disturb);
    longint unsigned ef;
    bit eo;
    int n;
    int exp_lat;
    model(x, 8, ef, eo);
    exp_lat = ((x > 1) ? x : 1) + 2;
    X = 8'(x);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 1;
    chk("busy_set", busy, 1);
    while (done !== 1'b1 && n < 300) begin
      start = disturb && (n == 2);
      if (disturb && n == 3) X = 8'd7;
      if (n == 2) chk("fi_hold", fi_out, prev_f);
      @(negedge CLK);
      n++;
    end
    start = 1'b0;
    chk($sformatf("latency_x%0d", x), n, exp_lat);
    chk($sformatf("fi_x%0d", x), fi_out, ef);
    chk($sformatf("ovf_x%0d", x), ovf, eo);
    chk("busy_in_done", busy, 1);
    @(negedge CLK);
    chk("done_pulse", done, 0);
    chk("busy_clr", busy, 0);
    prev_f = ef;
  endtask

  task automatic run16(input int x);
    longint unsigned ef;
    bit eo;
    int n;
    model(x, 16, ef, eo);
    X16 = 8'(x);
    start16 = 1'b1;
    @(negedge CLK);
    start16 = 1'b0;
    n = 1;
    while (done16 !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("lat16_x%0d", x), n, ((x > 1) ? x : 1) + 2);
    chk($sformatf("fi16_x%0d", x), fi16, ef);
    chk($sformatf("ovf16_x%0d", x), ovf16, eo);
    @(negedge CLK);
  endtask

  initial begin
    int pulses;
    RST_N = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    X = '0;
    X16 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fi", fi_out, 0);
    chk("rst_ovf", ovf, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    run8(5, 0);
    run8(0, 0);
    run8(1, 0);
    run8(6, 0);
`ifdef FACT_OVF_SAT_EN
    chk("x6_const", fi_out, 255);
`else
    chk("x6_const", fi_out, 208);
`endif
    run8(4, 1);
    chk("x4_const", fi_out, 24);

    // Abort a run with a one-edge reset in the middle.
    X = 8'd5;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fi", fi_out, 0);
    chk("abort_ovf", ovf, 0);
    pulses = 0;
    repeat (10) begin
      @(negedge CLK);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    prev_f = 0;
    run8(3, 0);
    run8(255, 0);

    repeat (20) run8(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

    run16(8);
    run16(9);
    repeat (4) run16(int'($urandom_range(0, 12)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
